// File: rtl/mul_operand_sequencer.sv
// Operand sequencer for a shift-add multiplier: buffers operand pairs in a 2-deep FIFO,
// issues start/A/B to the multiplier, then waits for done (or timeout) and holds the result.
module mul_operand_sequencer #(
   parameter int TIMEOUT = 70000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        op_ready,
   output logic        start,
   output logic [15:0] data_in,
   input  logic        done,
   input  logic [15:0] product,
   output logic        res_valid,
   output logic [15:0] res_data,
   output logic        res_err,
   input  logic        res_ready,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      LOAD_A = 3'd2,
      LOAD_B = 3'd3,
      WAIT   = 3'd4,
      RESULT = 3'd5
   } state_t;

   localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

   state_t      state_q, state_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] mem_q [2];
   logic [31:0] mem_d [2];
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [16:0] wait_cnt_q, wait_cnt_d;
   logic        start_q, start_d;
   logic [15:0] data_in_q, data_in_d;
   logic        res_valid_q, res_valid_d;
   logic [15:0] res_data_q, res_data_d;
   logic        res_err_q, res_err_d;
   logic        push, pop;

   // op_ready depends only on the registered count, never on this cycle's pop.
   assign op_ready  = (count_q != 2'd2);
   assign start     = start_q;
   assign data_in   = data_in_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      mem_d       = mem_q;
      a_d         = a_q;
      b_d         = b_q;
      wait_cnt_d  = wait_cnt_q;
      start_d     = 1'b0;
      data_in_d   = 16'h0000;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;

      push = op_valid && (count_q != 2'd2);
      pop  = (state_q == IDLE) && (count_q != 2'd0);

      if (push) begin
         mem_d[wr_ptr_q] = {op_a, op_b};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         {a_d, b_d} = mem_q[rd_ptr_q];
         rd_ptr_d   = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = START;
               start_d = 1'b1;
            end
         end
         START: begin
            state_d   = LOAD_A;
            data_in_d = a_q;
         end
         LOAD_A: begin
            state_d   = LOAD_B;
            data_in_d = b_q;
         end
         LOAD_B: begin
            state_d    = WAIT;
            wait_cnt_d = 17'd0;
         end
         WAIT: begin
            // done wins over an abort that would fire in the same cycle.
            if (done) begin
               res_data_d  = product;
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               state_d     = RESULT;
            end else if (wait_cnt_q == TIMEOUT_CNT) begin
               res_data_d  = 16'hFFFF;
               res_err_d   = 1'b1;
               res_valid_d = 1'b1;
               state_d     = RESULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 17'd1;
            end
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= 2'd0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         mem_q       <= '{default: '0};
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         wait_cnt_q  <= 17'd0;
         start_q     <= 1'b0;
         data_in_q   <= 16'h0000;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'h0000;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_q       <= mem_d;
         a_q         <= a_d;
         b_q         <= b_d;
         wait_cnt_q  <= wait_cnt_d;
         start_q     <= start_d;
         data_in_q   <= data_in_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
      end
   end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: a behavioural multiplier responder, a result scoreboard
// fed from the pushed operand pairs, and one task per scenario.
module tb_mul_operand_sequencer;

   localparam int TB_TIMEOUT = 20;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_ready;
   logic        start;
   logic [15:0] data_in;
   logic        done;
   logic [15:0] product;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_err;
   logic        res_ready;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic        exp_err_q[$];

   logic        rand_ready;
   logic        mult_en;
   logic        mult_rand;
   int          mult_delay;
   int          resp_delay;
   logic [15:0] cap_a, cap_b;
   logic [15:0] mon_e;
   logic        mon_ee;

   mul_operand_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_ready  (op_ready),
      .start     (start),
      .data_in   (data_in),
      .done      (done),
      .product   (product),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_err   (res_err),
      .res_ready (res_ready),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural multiplier: latch A and B after start, answer after a delay in WAIT
   always begin
      @(negedge clk);
      if (rst_n && start) begin
         @(negedge clk);
         cap_a = data_in;
         @(negedge clk);
         cap_b = data_in;
         @(negedge clk);
         resp_delay = mult_rand ? int'($urandom_range(0, 8)) : mult_delay;
         repeat (resp_delay) @(negedge clk);
         if (mult_en) begin
            done    = 1'b1;
            product = 16'(cap_a * cap_b);
            @(negedge clk);
            done = 1'b0;
         end
      end
   end

   // scoreboard: evaluated just before the posedge that performs the handshake
   always @(negedge clk) begin
      #3;
      if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
      if (rst_n && res_valid && res_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got data=%h err=%b, required no result", res_data, res_err);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_ee = exp_err_q.pop_front();
            if (res_data !== mon_e || res_err !== mon_ee) begin
               n_fail++;
               $display("FAIL result: got data=%h err=%b, required data=%h err=%b",
                        res_data, res_err, mon_e, mon_ee);
            end
         end
      end
   end

   // driver tasks
   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      int guard = 0;
      @(negedge clk);
      while (!op_ready && guard < 500) begin
         guard++;
         @(negedge clk);
      end
      n_checks++;
      if (!op_ready) begin
         n_fail++;
         $display("FAIL push_wait: op_ready=%b after %0d cycles, required 1", op_ready, guard);
      end
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic expect_res(input logic [15:0] d, input logic e);
      exp_q.push_back(d);
      exp_err_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding after %0d cycles, required 0", exp_q.size(), c);
         exp_q.delete();
         exp_err_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // scenario tasks
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({start, data_in, res_valid, res_data, res_err, op_ready} !== {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_outputs: got start=%b din=%h rv=%b rd=%h re=%b rdy=%b, required 0 0 0 0 0 1",
                  start, data_in, res_valid, res_data, res_err, op_ready);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [15:0] a = 16'd6;
      logic [15:0] b = 16'd5;
      mult_delay = 0;
      expect_res(16'(a * b), 1'b0);
      push_pair(a, b);
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0) begin n_fail++; $display("FAIL basic_start_t1: got %b, required 0", start); end
      @(negedge clk);
      n_checks++;
      if (start !== 1'b1 || data_in !== 16'h0) begin
         n_fail++; $display("FAIL basic_start_t2: got start=%b din=%h, required 1 0000", start, data_in);
      end
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0 || data_in !== a) begin
         n_fail++; $display("FAIL basic_a_t3: got start=%b din=%h, required 0 %h", start, data_in, a);
      end
      @(negedge clk);
      n_checks++;
      if (data_in !== b) begin n_fail++; $display("FAIL basic_b_t4: got %h, required %h", data_in, b); end
      @(negedge clk);
      n_checks++;
      if (data_in !== 16'h0 || res_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_wait_t5: got din=%h rv=%b, required 0000 0", data_in, res_valid);
      end
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 16'd30 || res_err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result_t6: got rv=%b rd=%h re=%b, required 1 001e 0", res_valid, res_data, res_err);
      end
      drain(50);
   endtask

   task automatic test_back_to_back;
      mult_delay = 3;
      expect_res(16'd6, 1'b0);
      expect_res(16'd16, 1'b0);
      expect_res(16'd7, 1'b0);
      push_pair(16'd2, 16'd3);
      push_pair(16'd4, 16'd4);
      push_pair(16'd7, 16'd1);
      @(negedge clk);
      n_checks++;
      if (op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: op_ready=%b, required 0", op_ready); end
      drain(200);
   endtask

   task automatic test_backpressure;
      int guard = 0;
      mult_delay = 2;
      res_ready  = 1'b0;
      expect_res(16'd143, 1'b0);
      expect_res(16'd21, 1'b0);
      expect_res(16'd4, 1'b0);
      push_pair(16'd11, 16'd13);
      push_pair(16'd3, 16'd7);
      while (!res_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (op_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: op_ready=%b, required 1", op_ready); end
      push_pair(16'd2, 16'd2);
      @(negedge clk);
      n_checks++;
      if (op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: op_ready=%b, required 0", op_ready); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (res_valid !== 1'b1 || res_data !== 16'd143 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got rv=%b rd=%h start=%b, required 1 008f 0", i, res_valid, res_data, start);
         end
      end
      res_ready = 1'b1;
      drain(200);
   endtask

   task automatic test_zero;
      mult_delay = 0;
      expect_res(16'd0, 1'b0);
      push_pair(16'd9, 16'd0);
      drain(50);
   endtask

   task automatic test_timeout;
      mult_en = 1'b0;
      expect_res(16'hFFFF, 1'b1);
      push_pair(16'd1, 16'd2);
      // WAIT is entered 5 cycles after the push; abort fires when the counter reaches TIMEOUT
      repeat (5 + TB_TIMEOUT) @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early: rv=%b, required 0", res_valid); end
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 16'hFFFF || res_err !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_result: got rv=%b rd=%h re=%b, required 1 ffff 1", res_valid, res_data, res_err);
      end
      drain(50);
      mult_en = 1'b1;
   endtask

   task automatic test_random;
      logic [15:0] a, b;
      rand_ready = 1'b1;
      mult_rand  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         expect_res(16'(a * b), 1'b0);
         push_pair(a, b);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain(2000);
      rand_ready = 1'b0;
      mult_rand  = 1'b0;
      res_ready  = 1'b1;
   endtask

   task automatic test_reset_in_wait;
      int bad = 0;
      logic [15:0] rd_before;
      mult_delay = 15;
      push_pair(16'd3, 16'd3);
      push_pair(16'd5, 16'd5);
      repeat (6) @(negedge clk);
      rd_before = res_data;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({start, data_in, res_valid, res_data, res_err, op_ready} !== {1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL async_reset: got start=%b din=%h rv=%b rd=%h (was %h) re=%b rdy=%b, required 0 0 0 0 0 1",
                  start, data_in, res_valid, res_data, rd_before, res_err, op_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (res_valid || start) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL reset_stale: %0d cycles with start/res_valid after reset, required 0", bad);
      end
      mult_delay = 1;
      expect_res(16'd64, 1'b0);
      push_pair(16'd8, 16'd8);
      drain(50);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, state=%0d", dbg_state);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      rst_n      = 1'b0;
      op_valid   = 1'b0;
      op_a       = 16'h0;
      op_b       = 16'h0;
      done       = 1'b0;
      product    = 16'h0;
      res_ready  = 1'b1;
      rand_ready = 1'b0;
      mult_en    = 1'b1;
      mult_rand  = 1'b0;
      mult_delay = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_zero();
      test_timeout();
      test_random();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
